axi4_lite_system: RTL and testbench

Self-contained AXI4-Lite subsystem: a master that converts simple local write/read requests into AXI4-Lite transactions, an internal bus interface, and a memory-backed slave.
- Used as the reference bus endpoint for channel-level protocol checking.
- Also gives the verification team a write/read-back path to exercise the five AXI4-Lite channels: AW, W, B, AR and R.

---
 rtl/axi4_lite_system_if.sv | 37 +++
 rtl/axi4_lite_system.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_axi4_lite_system.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_system_if.sv
// AXI4-Lite bus bundle (AW, W, B, AR, R) shared by the master and slave of axi4_lite_system.
interface axi4_lite_system_if #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32
) ();
  logic [Addr_Width-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [Data_Width-1:0] WDATA;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [Addr_Width-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [Data_Width-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport monitor (
    input AWADDR, AWVALID, AWREADY, WDATA, WVALID, WREADY, BRESP, BVALID, BREADY,
    input ARADDR, ARVALID, ARREADY, RDATA, RRESP, RVALID, RREADY
  );
endinterface

// File: rtl/axi4_lite_system.sv
// AXI4-Lite subsystem: local-request master, memory-backed slave and the bus between them.
// Define AXI_ASSERT_EN to compile the channel protocol checkers into axi4_lite_system.
module axi4_lite_system_master #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_en,
  input  logic [Addr_Width-1:0] Write_Address,
  input  logic [Data_Width-1:0] Write_Data,
  input  logic                  rd_en,
  input  logic [Addr_Width-1:0] Read_Address,
  output logic [Data_Width-1:0] Read_Data,
  output logic                  write_done,
  output logic                  read_done,
  output logic [1:0]            write_resp,
  output logic [1:0]            read_resp,
  axi4_lite_system_if.master    bus
);
  localparam logic [1:0] W_IDLE = 2'd0, W_REQ = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_REQ = 2'd1, R_DATA = 2'd2;

  logic [1:0]            wstate_q, rstate_q;
  logic                  awvalid_q, wvalid_q, arvalid_q;
  logic [Addr_Width-1:0] awaddr_q, araddr_q;
  logic [Data_Width-1:0] wdata_q, read_data_q;
  logic                  write_done_q, read_done_q;
  logic [1:0]            write_resp_q, read_resp_q;
  logic                  w_accept, r_accept, aw_done, w_done;

  assign w_accept = (wstate_q == W_IDLE) && wr_en;
  assign r_accept = (rstate_q == R_IDLE) && rd_en;
  // A channel counts as done once its VALID has dropped or is handshaking this cycle.
  assign aw_done  = !awvalid_q || bus.AWREADY;
  assign w_done   = !wvalid_q || bus.WREADY;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wstate_q     <= W_IDLE;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      write_done_q <= 1'b0;
      write_resp_q <= 2'b00;
    end else begin
      write_done_q <= 1'b0;
      case (wstate_q)
        W_IDLE: if (w_accept) begin
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          wstate_q  <= W_REQ;
        end
        W_REQ: begin
          if (bus.AWREADY) awvalid_q <= 1'b0;
          if (bus.WREADY)  wvalid_q  <= 1'b0;
          if (aw_done && w_done) wstate_q <= W_RESP;
        end
        W_RESP: if (bus.BVALID) begin
          write_resp_q <= bus.BRESP;
          write_done_q <= 1'b1;
          wstate_q     <= W_IDLE;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      rstate_q    <= R_IDLE;
      arvalid_q   <= 1'b0;
      read_done_q <= 1'b0;
      read_resp_q <= 2'b00;
      read_data_q <= '0;
    end else begin
      read_done_q <= 1'b0;
      case (rstate_q)
        R_IDLE: if (r_accept) begin
          arvalid_q <= 1'b1;
          rstate_q  <= R_REQ;
        end
        R_REQ: if (bus.ARREADY) begin
          arvalid_q <= 1'b0;
          rstate_q  <= R_DATA;
        end
        R_DATA: if (bus.RVALID) begin
          read_data_q <= bus.RDATA;
          read_resp_q <= bus.RRESP;
          read_done_q <= 1'b1;
          rstate_q    <= R_IDLE;
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  // Request payloads are only meaningful while VALID is high, so they carry no reset.
  always_ff @(posedge ACLK) begin
    if (w_accept) begin
      awaddr_q <= Write_Address;
      wdata_q  <= Write_Data;
    end
    if (r_accept) araddr_q <= Read_Address;
  end

  assign bus.AWADDR  = awaddr_q;
  assign bus.AWVALID = awvalid_q;
  assign bus.WDATA   = wdata_q;
  assign bus.WVALID  = wvalid_q;
  assign bus.BREADY  = (wstate_q == W_RESP);
  assign bus.ARADDR  = araddr_q;
  assign bus.ARVALID = arvalid_q;
  assign bus.RREADY  = (rstate_q == R_DATA);
  assign Read_Data   = read_data_q;
  assign write_done  = write_done_q;
  assign read_done   = read_done_q;
  assign write_resp  = write_resp_q;
  assign read_resp   = read_resp_q;
endmodule

module axi4_lite_system_slave #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic              ACLK,
  input  logic              ARESETN,
  axi4_lite_system_if.slave bus
);
  localparam int IW = $clog2(MEM_DEPTH);
  localparam logic [0:0] S_W_IDLE = 1'b0, S_W_RESP = 1'b1;
  localparam logic [0:0] S_R_IDLE = 1'b0, S_R_DATA = 1'b1;

  logic [Data_Width-1:0] mem [MEM_DEPTH];
  logic [0:0]            swstate_q, srstate_q;
  logic                  awready_q, wready_q, aw_got_q, w_got_q, bvalid_q, arready_q, rvalid_q;
  logic [1:0]            bresp_q, rresp_q;
  logic [Addr_Width-1:0] awaddr_q;
  logic [Data_Width-1:0] wdata_q, rdata_q;
  logic                  aw_hs, w_hs, ar_hs, aw_have, w_have, wr_ok, rd_ok, mem_we;
  logic [Addr_Width-1:0] wr_addr;
  logic [Data_Width-1:0] wr_data;

  assign aw_hs   = bus.AWVALID && awready_q;
  assign w_hs    = bus.WVALID && wready_q;
  assign ar_hs   = bus.ARVALID && arready_q;
  assign aw_have = aw_got_q || aw_hs;
  assign w_have  = w_got_q || w_hs;
  // The channel completing this cycle supplies its value straight from the bus.
  assign wr_addr = aw_hs ? bus.AWADDR : awaddr_q;
  assign wr_data = w_hs ? bus.WDATA : wdata_q;
  assign wr_ok   = wr_addr < Addr_Width'(MEM_DEPTH);
  assign rd_ok   = bus.ARADDR < Addr_Width'(MEM_DEPTH);
  assign mem_we  = (swstate_q == S_W_IDLE) && aw_have && w_have && wr_ok;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      swstate_q <= S_W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else if (swstate_q == S_W_IDLE) begin
      if (aw_have && w_have) begin
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_ok ? 2'b00 : 2'b10;
        awready_q <= 1'b0;
        wready_q  <= 1'b0;
        aw_got_q  <= 1'b0;
        w_got_q   <= 1'b0;
        swstate_q <= S_W_RESP;
      end else begin
        aw_got_q  <= aw_have;
        w_got_q   <= w_have;
        awready_q <= !aw_have;
        wready_q  <= !w_have;
      end
    end else if (bus.BREADY) begin
      bvalid_q  <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      swstate_q <= S_W_IDLE;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      srstate_q <= S_R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
    end else if (srstate_q == S_R_IDLE) begin
      if (ar_hs) begin
        rvalid_q  <= 1'b1;
        rresp_q   <= rd_ok ? 2'b00 : 2'b10;
        arready_q <= 1'b0;
        srstate_q <= S_R_DATA;
      end else begin
        arready_q <= 1'b1;
      end
    end else if (bus.RREADY) begin
      rvalid_q  <= 1'b0;
      arready_q <= 1'b1;
      srstate_q <= S_R_IDLE;
    end
  end

  // Read and write share an edge, so a colliding read sees the pre-write word.
  always_ff @(posedge ACLK) begin
    if (aw_hs)  awaddr_q <= bus.AWADDR;
    if (w_hs)   wdata_q  <= bus.WDATA;
    if (mem_we) mem[wr_addr[IW-1:0]] <= wr_data;
    if (ar_hs)  rdata_q  <= rd_ok ? mem[bus.ARADDR[IW-1:0]] : '0;
  end

  assign bus.AWREADY = awready_q;
  assign bus.WREADY  = wready_q;
  assign bus.BVALID  = bvalid_q;
  assign bus.BRESP   = bresp_q;
  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RRESP   = rresp_q;
  assign bus.RDATA   = rdata_q;
endmodule

module axi4_lite_system #(
  parameter int Addr_Width = 32,
  parameter int Data_Width = 32,
  parameter int MEM_DEPTH  = 4096
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  wr_en,
  input  logic [Addr_Width-1:0] Write_Address,
  input  logic [Data_Width-1:0] Write_Data,
  input  logic                  rd_en,
  input  logic [Addr_Width-1:0] Read_Address,
  output logic [Data_Width-1:0] Read_Data,
  output logic                  write_done,
  output logic                  read_done,
  output logic [1:0]            write_resp,
  output logic [1:0]            read_resp
);
  axi4_lite_system_if #(.Addr_Width(Addr_Width), .Data_Width(Data_Width)) bus ();

  axi4_lite_system_master #(.Addr_Width(Addr_Width), .Data_Width(Data_Width)) u_mst (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_en(wr_en), .Write_Address(Write_Address), .Write_Data(Write_Data),
    .rd_en(rd_en), .Read_Address(Read_Address), .Read_Data(Read_Data),
    .write_done(write_done), .read_done(read_done),
    .write_resp(write_resp), .read_resp(read_resp),
    .bus(bus.master)
  );

  axi4_lite_system_slave #(
    .Addr_Width(Addr_Width), .Data_Width(Data_Width), .MEM_DEPTH(MEM_DEPTH)
  ) u_slv (
    .ACLK(ACLK), .ARESETN(ARESETN), .bus(bus.slave)
  );

`ifdef AXI_ASSERT_EN
  logic [Addr_Width-1:0] exp_awaddr_q, exp_araddr_q;
  logic [Data_Width-1:0] exp_wdata_q;

  // Shadow of the request the master accepted, for checking what reaches the bus.
  always_ff @(posedge ACLK) begin
    if (u_mst.w_accept) begin
      exp_awaddr_q <= Write_Address;
      exp_wdata_q  <= Write_Data;
    end
    if (u_mst.r_accept) exp_araddr_q <= Read_Address;
  end

  property p_stable(v, r, d);
    @(posedge ACLK) disable iff (!ARESETN) v && !r |=> $stable(d);
  endproperty
  property p_known_when(v, d);
    @(posedge ACLK) disable iff (!ARESETN) v |-> !$isunknown(d);
  endproperty
  property p_low_in_reset(v, r);
    @(posedge ACLK) !ARESETN |-> !v && !r;
  endproperty
  property p_hold(a, b);
    @(posedge ACLK) disable iff (!ARESETN) a && !b |=> a;
  endproperty
  property p_known(v, r);
    @(posedge ACLK) disable iff (!ARESETN) !$isunknown({v, r});
  endproperty
  property p_match(v, r, d, e);
    @(posedge ACLK) disable iff (!ARESETN) v && r |-> d == e;
  endproperty

  a_aw_stable: assert property (p_stable(bus.AWVALID, bus.AWREADY, bus.AWADDR)) else $error("AWADDR changed while AWVALID held");
  a_aw_known:  assert property (p_known_when(bus.AWVALID, bus.AWADDR)) else $error("AWADDR unknown while AWVALID high");
  a_aw_rst:    assert property (p_low_in_reset(bus.AWVALID, bus.AWREADY)) else $error("AWVALID/AWREADY high in reset");
  a_aw_vhold:  assert property (p_hold(bus.AWVALID, bus.AWREADY)) else $error("AWVALID dropped before AWREADY");
  a_aw_rhold:  assert property (p_hold(bus.AWREADY, bus.AWVALID)) else $error("AWREADY dropped before AWVALID");
  a_aw_vrx:    assert property (p_known(bus.AWVALID, bus.AWREADY)) else $error("AWVALID/AWREADY unknown");
  a_aw_match:  assert property (p_match(bus.AWVALID, bus.AWREADY, bus.AWADDR, exp_awaddr_q)) else $error("AWADDR differs from Write_Address");
  a_w_stable:  assert property (p_stable(bus.WVALID, bus.WREADY, bus.WDATA)) else $error("WDATA changed while WVALID held");
  a_w_known:   assert property (p_known_when(bus.WVALID, bus.WDATA)) else $error("WDATA unknown while WVALID high");
  a_w_rst:     assert property (p_low_in_reset(bus.WVALID, bus.WREADY)) else $error("WVALID/WREADY high in reset");
  a_w_vhold:   assert property (p_hold(bus.WVALID, bus.WREADY)) else $error("WVALID dropped before WREADY");
  a_w_rhold:   assert property (p_hold(bus.WREADY, bus.WVALID)) else $error("WREADY dropped before WVALID");
  a_w_vrx:     assert property (p_known(bus.WVALID, bus.WREADY)) else $error("WVALID/WREADY unknown");
  a_w_match:   assert property (p_match(bus.WVALID, bus.WREADY, bus.WDATA, exp_wdata_q)) else $error("WDATA differs from Write_Data");
  a_ar_stable: assert property (p_stable(bus.ARVALID, bus.ARREADY, bus.ARADDR)) else $error("ARADDR changed while ARVALID held");
  a_ar_known:  assert property (p_known_when(bus.ARVALID, bus.ARADDR)) else $error("ARADDR unknown while ARVALID high");
  a_ar_rst:    assert property (p_low_in_reset(bus.ARVALID, bus.ARREADY)) else $error("ARVALID/ARREADY high in reset");
  a_ar_vhold:  assert property (p_hold(bus.ARVALID, bus.ARREADY)) else $error("ARVALID dropped before ARREADY");
  a_ar_rhold:  assert property (p_hold(bus.ARREADY, bus.ARVALID)) else $error("ARREADY dropped before ARVALID");
  a_ar_vrx:    assert property (p_known(bus.ARVALID, bus.ARREADY)) else $error("ARVALID/ARREADY unknown");
  a_ar_match:  assert property (p_match(bus.ARVALID, bus.ARREADY, bus.ARADDR, exp_araddr_q)) else $error("ARADDR differs from Read_Address");
`endif
endmodule

// File: tb/tb_axi4_lite_system.sv
// Randomized scoreboard bench for axi4_lite_system with a behavioural memory model.
`timescale 1ns/1ps
module tb_axi4_lite_system;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4096;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [AW-1:0] Write_Address = '0;
  logic [DW-1:0] Write_Data = '0;
  logic [AW-1:0] Read_Address = '0;
  logic [DW-1:0] Read_Data;
  logic          write_done, read_done;
  logic [1:0]    write_resp, read_resp;

  always #5 ACLK = ~ACLK;

  axi4_lite_system #(.Addr_Width(AW), .Data_Width(DW), .MEM_DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .wr_en(wr_en), .Write_Address(Write_Address), .Write_Data(Write_Data),
    .rd_en(rd_en), .Read_Address(Read_Address), .Read_Data(Read_Data),
    .write_done(write_done), .read_done(read_done),
    .write_resp(write_resp), .read_resp(read_resp)
  );

  axi4_lite_system_if #(.Addr_Width(AW), .Data_Width(DW)) mon ();
  assign mon.AWADDR  = dut.bus.AWADDR;
  assign mon.AWVALID = dut.bus.AWVALID;
  assign mon.AWREADY = dut.bus.AWREADY;
  assign mon.WDATA   = dut.bus.WDATA;
  assign mon.WVALID  = dut.bus.WVALID;
  assign mon.WREADY  = dut.bus.WREADY;
  assign mon.BRESP   = dut.bus.BRESP;
  assign mon.BVALID  = dut.bus.BVALID;
  assign mon.BREADY  = dut.bus.BREADY;
  assign mon.ARADDR  = dut.bus.ARADDR;
  assign mon.ARVALID = dut.bus.ARVALID;
  assign mon.ARREADY = dut.bus.ARREADY;
  assign mon.RDATA   = dut.bus.RDATA;
  assign mon.RRESP   = dut.bus.RRESP;
  assign mon.RVALID  = dut.bus.RVALID;
  assign mon.RREADY  = dut.bus.RREADY;

  logic [DW-1:0] model_mem [DEPTH];
  logic [AW-1:0] exp_aw_q[$];
  logic [AW-1:0] exp_ar_q[$];
  logic [DW-1:0] exp_w_q[$];
  logic [1:0]    exp_b_q[$];
  logic [33:0]   exp_r_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit held_mode = 1'b0;
  int last_wd  = -1;
  int held_pulses = 0;

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event seen with no expectation queued (t=%0t)", nm, $time);
  endtask

  function automatic logic [33:0] model_read(input logic [31:0] a);
    if (a < DEPTH) return {2'b00, model_mem[a[11:0]]};
    return {2'b10, 32'h0};
  endfunction

  function automatic logic [31:0] pick_addr();
    int unsigned k;
    k = $urandom_range(0, 19);
    if (k == 0) return 32'h0000_1000;
    if (k == 1) return 32'hFFFF_FFFF;
    if (k == 2) return 32'h0000_1000 + $urandom_range(1, 1000);
    if (k - 3 < 16) return 32'h100 + (k - 3);
    return 32'hFFF;
  endfunction

  // Monitor: peeks at bus handshakes, pops on completion pulses.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (mon.AWVALID && mon.AWREADY) begin
        if (exp_aw_q.size() == 0) unexpected("aw_handshake");
        else chk("awaddr_at_handshake", mon.AWADDR, exp_aw_q.pop_front());
      end
      if (mon.WVALID && mon.WREADY) begin
        if (exp_w_q.size() == 0) unexpected("w_handshake");
        else chk("wdata_at_handshake", mon.WDATA, exp_w_q.pop_front());
      end
      if (mon.ARVALID && mon.ARREADY) begin
        if (exp_ar_q.size() == 0) unexpected("ar_handshake");
        else chk("araddr_at_handshake", mon.ARADDR, exp_ar_q.pop_front());
      end
      if (mon.BVALID && mon.BREADY && exp_b_q.size() != 0)
        chk("bus_bresp", mon.BRESP, exp_b_q[0]);
      if (mon.RVALID && mon.RREADY && exp_r_q.size() != 0)
        chk("bus_rdata", {mon.RRESP, mon.RDATA}, exp_r_q[0]);
      if (write_done) begin
        if (exp_b_q.size() == 0) unexpected("write_done");
        else chk("write_resp", write_resp, exp_b_q.pop_front());
        if (held_mode) begin
          if (last_wd >= 0) chk("write_done_spacing", cyc - last_wd, 3);
          last_wd = cyc;
          held_pulses++;
        end
      end
      if (read_done) begin
        logic [33:0] e;
        if (exp_r_q.size() == 0) unexpected("read_done");
        else begin
          e = exp_r_q.pop_front();
          chk("read_data", Read_Data, e[31:0]);
          chk("read_resp", read_resp, e[33:32]);
        end
      end
    end
  end

  task automatic issue(input bit do_w, input logic [31:0] wa, input logic [31:0] wd,
                       input bit do_r, input logic [31:0] ra, input bit rd_late);
    if (do_r && !rd_late) begin
      exp_r_q.push_back(model_read(ra));
      exp_ar_q.push_back(ra);
    end
    if (do_w) begin
      exp_aw_q.push_back(wa);
      exp_w_q.push_back(wd);
      exp_b_q.push_back((wa < DEPTH) ? 2'b00 : 2'b10);
      if (wa < DEPTH) model_mem[wa[11:0]] = wd;
    end
    if (do_r && rd_late) begin
      exp_r_q.push_back(model_read(ra));
      exp_ar_q.push_back(ra);
    end
    @(negedge ACLK);
    wr_en = do_w; Write_Address = wa; Write_Data = wd;
    rd_en = do_r && !rd_late; Read_Address = ra;
    @(negedge ACLK);
    wr_en = 1'b0; Write_Address = $urandom; Write_Data = $urandom;
    rd_en = do_r && rd_late;
    if (!rd_late) Read_Address = $urandom;
    @(negedge ACLK);
    rd_en = 1'b0; Read_Address = $urandom;
    repeat (3) @(negedge ACLK);
  endtask

  initial begin
    logic [31:0] a, b, d;
    int unsigned kind;

    // Reset state
    repeat (2) @(negedge ACLK);
    chk("rst_valids", {mon.AWVALID, mon.WVALID, mon.BVALID, mon.ARVALID, mon.RVALID}, 5'b0);
    chk("rst_readys", {mon.AWREADY, mon.WREADY, mon.BREADY, mon.ARREADY, mon.RREADY}, 5'b0);
    chk("rst_dones", {write_done, read_done}, 2'b00);
    chk("rst_resps", {write_resp, read_resp}, 4'b0);
    chk("rst_read_data", Read_Data, 32'h0);
    ARESETN = 1'b1;
    @(posedge ACLK); #1;
    chk("readys_after_release", {mon.AWREADY, mon.WREADY, mon.ARREADY}, 3'b111);

    // Basic write / read-back
    issue(1'b1, 32'h246, 32'h2468_1357, 1'b0, 32'h0, 1'b0);
    chk("mem_246", dut.u_slv.mem[12'h246], 32'h2468_1357);
    issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h246, 1'b0);

    // Out of range: must not alias onto word 0
    issue(1'b1, 32'h0, 32'hA5A5_A5A5, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 32'h1000, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h1000, 1'b0);
    chk("mem_0_unchanged", dut.u_slv.mem[12'h000], 32'hA5A5_A5A5);
    issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0);

    // Read-before-write on aligned handshakes, then the new value
    issue(1'b1, 32'h10, 32'h1111_1111, 1'b0, 32'h0, 1'b0);
    issue(1'b1, 32'h10, 32'h2222_2222, 1'b1, 32'h10, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0);

    // Reset while AWVALID is high
    @(negedge ACLK);
    wr_en = 1'b1; Write_Address = 32'h246; Write_Data = 32'h0BAD_F00D;
    @(posedge ACLK); #1;
    wr_en = 1'b0;
    chk("awvalid_before_reset", mon.AWVALID, 1'b1);
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_valids", {mon.AWVALID, mon.WVALID, mon.BVALID}, 3'b000);
    chk("mid_rst_read_data", Read_Data, 32'h0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    chk("mid_rst_mem_unchanged", dut.u_slv.mem[12'h246], model_mem[12'h246]);
    issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h246, 1'b0);
    issue(1'b1, 32'h246, 32'h1357_2468, 1'b0, 32'h0, 1'b0);
    issue(1'b0, 32'h0, 32'h0, 1'b1, 32'h246, 1'b0);

    // wr_en held for 12 edges: one write every 3 cycles
    d = 32'hC0DE_0105;
    for (int i = 0; i < 4; i++) begin
      exp_aw_q.push_back(32'h105);
      exp_w_q.push_back(d);
      exp_b_q.push_back(2'b00);
    end
    model_mem[12'h105] = d;
    held_mode = 1'b1; last_wd = -1; held_pulses = 0;
    @(negedge ACLK);
    wr_en = 1'b1; Write_Address = 32'h105; Write_Data = d;
    repeat (12) @(negedge ACLK);
    wr_en = 1'b0;
    repeat (4) @(negedge ACLK);
    held_mode = 1'b0;
    chk("held_write_count", held_pulses, 4);

    // Seed every pool address, then random mixed traffic
    for (int i = 0; i < 17; i++) begin
      a = (i < 16) ? 32'h100 + i : 32'hFFF;
      issue(1'b1, a, $urandom, 1'b0, 32'h0, 1'b0);
    end
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      a = pick_addr();
      b = ($urandom_range(0, 1) == 1) ? a : pick_addr();
      issue(kind != 1, a, $urandom, kind != 0, b, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 50; i++) begin
      if (exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_b_q.size() + exp_r_q.size() == 0) break;
      @(negedge ACLK);
    end
    chk("scoreboard_drained",
        exp_aw_q.size() + exp_w_q.size() + exp_ar_q.size() + exp_b_q.size() + exp_r_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
